operand_loader: RTL and testbench

OPERAND_LOADER -- requirements
Module: operand_loader

---
 rtl/operand_loader.sv | 123 ++++++++++++
 tb/tb_operand_loader.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/operand_loader.sv
// Operand loader: collects A, B and OP words from a tagged pad stream, issues a
// one-cycle start to the FPU stage, then waits for done_calc under a watchdog.
module operand_loader #(
  parameter int OPW     = 10,
  parameter int TIMEOUT = 255
) (
  input  logic           clock,
  input  logic           reset_n,
  input  logic [11:0]    in_data,
  input  logic           in_valid,
  output logic           in_ready,
  output logic [OPW-1:0] num1,
  output logic [OPW-1:0] num2,
  output logic [3:0]     op,
  output logic           start,
  output logic           busy,
  input  logic           done_calc,
  output logic           error
);

  typedef enum logic [2:0] {IDLE, HAVE_A, HAVE_B, ISSUE, WAIT, ERR} state_t;
  typedef enum logic [1:0] {TAG_CLEAR, TAG_A, TAG_B, TAG_OP} tag_t;

  localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);

  state_t     state_q, state_d;
  tag_t       tag;
  logic       accept;
  logic [7:0] wdog;

  assign tag    = tag_t'(in_data[11:10]);
  assign accept = in_valid & in_ready;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:
        if (accept) begin
          case (tag)
            TAG_A:         state_d = HAVE_A;
            TAG_B, TAG_OP: state_d = ERR;
            default:       state_d = IDLE;
          endcase
        end
      HAVE_A:
        if (accept) begin
          case (tag)
            TAG_B:     state_d = HAVE_B;
            TAG_CLEAR: state_d = IDLE;
            TAG_OP:    state_d = ERR;
            default:   state_d = HAVE_A;
          endcase
        end
      HAVE_B:
        if (accept) begin
          case (tag)
            TAG_OP:    state_d = ISSUE;
            TAG_CLEAR: state_d = IDLE;
            default:   state_d = ERR;
          endcase
        end
      ISSUE: state_d = WAIT;
      // The WAIT cycle that sees wdog == TIMEOUT-1 is the TIMEOUT-th one.
      WAIT:
        if (done_calc)             state_d = IDLE;
        else if (wdog == WD_LAST)  state_d = ERR;
      ERR:
        if (accept && tag == TAG_CLEAR) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready = 1'b1;
    start    = 1'b0;
    busy     = 1'b0;
    error    = 1'b0;
    unique case (state_q)
      ISSUE: begin
        in_ready = 1'b0;
        start    = 1'b1;
        busy     = 1'b1;
      end
      WAIT: begin
        in_ready = 1'b0;
        busy     = 1'b1;
      end
      ERR:     error = 1'b1;
      default: ;
    endcase
  end

  // Payloads are captured only on legal transitions; erroneous words never land.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      num1 <= '0;
      num2 <= '0;
      op   <= '0;
    end else if (accept) begin
      if ((state_q == IDLE || state_q == HAVE_A) && tag == TAG_A)
        num1 <= OPW'(in_data[9:0]);
      if (state_q == HAVE_A && tag == TAG_B)
        num2 <= OPW'(in_data[9:0]);
      if (state_q == HAVE_B && tag == TAG_OP)
        op <= in_data[3:0];
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)
      wdog <= '0;
    else if (state_q == ISSUE)
      wdog <= '0;
    else if (state_q == WAIT && !done_calc && wdog != 8'hFF)
      wdog <= wdog + 8'd1;
  end

endmodule

// File: tb/tb_operand_loader.sv
// Bench for operand_loader: two instances (default and short watchdog) driven in
// lockstep and compared every cycle against a transaction-level reference model.
module tb_operand_loader;

  logic        clock;
  logic        reset_n;
  logic [11:0] in_data;
  logic        in_valid;
  logic        done_calc;

  logic       rdy0, st0, bz0, er0, rdy1, st1, bz1, er1;
  logic [9:0] n1_0, n2_0, n1_1, n2_1;
  logic [3:0] op0, op1;

  int checks   = 0;
  int failures = 0;

  operand_loader #(.OPW(10), .TIMEOUT(255)) dut0 (
    .clock(clock), .reset_n(reset_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(rdy0), .num1(n1_0), .num2(n2_0), .op(op0), .start(st0),
    .busy(bz0), .done_calc(done_calc), .error(er0)
  );

  operand_loader #(.OPW(10), .TIMEOUT(4)) dut1 (
    .clock(clock), .reset_n(reset_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(rdy1), .num1(n1_1), .num2(n2_1), .op(op1), .start(st1),
    .busy(bz1), .done_calc(done_calc), .error(er1)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    bit         got_a;
    bit         got_b;
    bit         issuing;
    bit         waiting;
    bit         err;
    int         waits;
    logic [9:0] n1;
    logic [9:0] n2;
    logic [3:0] op;
  } mdl_t;

  mdl_t m0, m1;

  function automatic mdl_t mdl_reset();
    mdl_t r;
    r.got_a = 0; r.got_b = 0; r.issuing = 0; r.waiting = 0; r.err = 0;
    r.waits = 0; r.n1 = '0; r.n2 = '0; r.op = '0;
    return r;
  endfunction

  function automatic mdl_t advance(mdl_t s, int lim, logic v, logic [11:0] d, logic dn);
    mdl_t       r;
    logic [1:0] t;
    bit         acc;
    bit         bad;
    r   = s;
    t   = d[11:10];
    acc = v && !(s.issuing || s.waiting);
    bad = 0;
    if (s.err) begin
      if (acc && t == 2'b00) r.err = 0;
    end else if (s.issuing) begin
      r.issuing = 0; r.waiting = 1; r.waits = 0;
    end else if (s.waiting) begin
      if (dn) r.waiting = 0;
      else begin
        r.waits = r.waits + 1;
        if (r.waits == lim) begin r.waiting = 0; r.err = 1; end
      end
    end else if (acc) begin
      case (t)
        2'b00: begin r.got_a = 0; r.got_b = 0; end
        2'b01: if (s.got_b) bad = 1; else begin r.n1 = d[9:0]; r.got_a = 1; end
        2'b10: if (s.got_a && !s.got_b) begin r.n2 = d[9:0]; r.got_b = 1; end else bad = 1;
        default:
          if (s.got_b) begin
            r.op = d[3:0]; r.issuing = 1; r.got_a = 0; r.got_b = 0;
          end else bad = 1;
      endcase
      if (bad) begin r.got_a = 0; r.got_b = 0; r.err = 1; end
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic cmp_one(input string who, input mdl_t s, input logic rdy, input logic [9:0] n1,
                         input logic [9:0] n2, input logic [3:0] o, input logic st,
                         input logic bz, input logic er);
    chk({who, ".in_ready"}, 32'(rdy), 32'(!(s.issuing || s.waiting)));
    chk({who, ".busy"},     32'(bz),  32'(s.issuing || s.waiting));
    chk({who, ".start"},    32'(st),  32'(s.issuing));
    chk({who, ".error"},    32'(er),  32'(s.err));
    chk({who, ".num1"},     32'(n1),  32'(s.n1));
    chk({who, ".num2"},     32'(n2),  32'(s.n2));
    chk({who, ".op"},       32'(o),   32'(s.op));
  endtask

  task automatic cmp_all();
    cmp_one("d0", m0, rdy0, n1_0, n2_0, op0, st0, bz0, er0);
    cmp_one("d1", m1, rdy1, n1_1, n2_1, op1, st1, bz1, er1);
  endtask

  // Compare at the negedge, clock, then advance the model with the inputs just seen.
  task automatic step();
    cmp_all();
    @(posedge clock);
    if (!reset_n) begin
      m0 = mdl_reset(); m1 = mdl_reset();
    end else begin
      m0 = advance(m0, 255, in_valid, in_data, done_calc);
      m1 = advance(m1, 4,   in_valid, in_data, done_calc);
    end
    @(negedge clock);
  endtask

  task automatic word(input logic [1:0] t, input logic [9:0] p);
    in_valid = 1'b1;
    in_data  = {t, p};
    step();
    in_valid = 1'b0;
  endtask

  task automatic idle(input int unsigned n);
    in_valid = 1'b0;
    for (int unsigned i = 0; i < n; i++) step();
  endtask

  task automatic resync();
    done_calc = 1'b1;
    idle(1);
    done_calc = 1'b0;
    word(2'b00, 10'h0);
    idle(1);
  endtask

  task automatic sequence_abo(input logic [9:0] a, input logic [9:0] b, input logic [3:0] o);
    word(2'b01, a);
    word(2'b10, b);
    word(2'b11, {6'h0, o});
  endtask

  initial begin
    int unsigned seqpos;
    logic [1:0]  t;
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    done_calc = 1'b0;
    m0 = mdl_reset();
    m1 = mdl_reset();
    @(negedge clock);
    chk("reset.in_ready", 32'(rdy0), 32'd1);
    step();
    reset_n = 1'b1;
    idle(2);

    // A/B/OP back to back, then done_calc on the 5th WAIT cycle
    sequence_abo(10'h155, 10'h2AA, 4'h3);
    chk("issue.start", 32'(st0), 32'd1);
    chk("issue.num1",  32'(n1_0), 32'h155);
    chk("issue.num2",  32'(n2_0), 32'h2AA);
    chk("issue.op",    32'(op0), 32'h3);
    chk("issue.ready", 32'(rdy0), 32'd0);
    done_calc = 1'b1;
    idle(1);
    done_calc = 1'b0;
    idle(4);
    chk("wait5.busy", 32'(bz0), 32'd1);
    done_calc = 1'b1;
    idle(1);
    done_calc = 1'b0;
    chk("done.busy",  32'(bz0), 32'd0);
    chk("done.ready", 32'(rdy0), 32'd1);
    chk("done.num1",  32'(n1_0), 32'h155);
    idle(2);
    resync();

    // Protocol error, discarded word, CLEAR recovery, normal issue
    word(2'b10, 10'h2AA);
    chk("err.error", 32'(er0), 32'd1);
    word(2'b01, 10'h0F0);
    chk("err.num1_kept", 32'(n1_0), 32'h155);
    word(2'b00, 10'h0);
    chk("clr.error", 32'(er0), 32'd0);
    sequence_abo(10'h011, 10'h022, 4'h5);
    chk("reissue.start", 32'(st0), 32'd1);
    idle(1);
    chk("no_double_start", 32'(st0), 32'd0);

    // Watchdog on the TIMEOUT=4 instance, then a late done_calc
    idle(4);
    chk("wd.error", 32'(er1), 32'd1);
    chk("wd.busy",  32'(bz1), 32'd0);
    done_calc = 1'b1;
    idle(1);
    done_calc = 1'b0;
    chk("wd.late_done", 32'(er1), 32'd1);
    resync();

    // Repeated A overwrites num1
    word(2'b01, 10'h001);
    word(2'b01, 10'h3FF);
    word(2'b10, 10'h0AB);
    word(2'b11, 10'h009);
    chk("overwrite.num1", 32'(n1_0), 32'h3FF);
    idle(3);

    // Asynchronous reset in WAIT abandons the transaction
    #2;
    reset_n = 1'b0;
    m0 = mdl_reset();
    m1 = mdl_reset();
    #1;
    chk("arst.busy", 32'(bz0), 32'd0);
    chk("arst.num1", 32'(n1_0), 32'd0);
    step();
    reset_n = 1'b1;
    idle(6);
    chk("arst.no_start", 32'(st0), 32'd0);

    // Random traffic biased toward legal A/B/OP order
    seqpos = 1;
    for (int unsigned i = 0; i < 3000; i++) begin
      done_calc = ($urandom % 12) == 0;
      in_valid  = ($urandom % 4) != 0;
      if (($urandom % 4) != 0) begin
        t = 2'(seqpos);
        if (in_valid) seqpos = (seqpos % 3) + 1;
      end else begin
        t = 2'($urandom % 4);
      end
      in_data = {t, 10'($urandom)};
      if (($urandom % 500) == 0) begin
        #2;
        reset_n = 1'b0;
        m0 = mdl_reset();
        m1 = mdl_reset();
        #1;
        step();
        reset_n = 1'b1;
      end else begin
        step();
      end
    end
    in_valid  = 1'b0;
    done_calc = 1'b0;
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
